// File: rtl/axi_burst_seq.sv
// AXI burst address sequencer: accepts one burst request and emits per-beat addresses.
// Optional WRAP support is compiled in when AXI_WRAP_BURST_EN is defined.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif

module axi_burst_seq (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req_valid,
  output logic                   o_req_ready,
  input  logic [`ADDR_WIDTH-1:0] i_req_addr,
  input  logic [`LEN_BITS-1:0]   i_req_len,
  input  logic [`SIZE_BITS-1:0]  i_req_size,
  input  logic [1:0]             i_req_burst,
  output logic                   o_beat_valid,
  input  logic                   i_beat_ready,
  output logic [`ADDR_WIDTH-1:0] o_beat_addr,
  output logic [`LEN_BITS-1:0]   o_beat_idx,
  output logic                   o_beat_last,
  output logic                   o_busy
);

  localparam int unsigned AW = `ADDR_WIDTH;
  localparam int unsigned LW = `LEN_BITS;
  localparam int unsigned SW = `SIZE_BITS;

  typedef enum logic {S_IDLE = 1'b0, S_BURST = 1'b1} state_e;

  state_e          state_q;
  logic [AW-1:0]   addr_q;
  logic [LW-1:0]   idx_q;
  logic            last_q;
  logic [LW-1:0]   len_q;
  logic [SW-1:0]   size_q;
  logic [1:0]      burst_q;

  logic [AW-1:0]   step;
  logic [AW-1:0]   incr_addr;
  logic [AW-1:0]   addr_d;
  logic [LW-1:0]   idx_d;

`ifdef AXI_WRAP_BURST_EN
  logic            wrap_len;
  logic [AW-1:0]   wrap_mask;
`endif

  // Address of the following beat, derived from the latched burst type.
  always_comb begin
    step      = AW'(1) << size_q;
    incr_addr = addr_q + step;
    addr_d    = incr_addr;
    idx_d     = idx_q + LW'(1);
`ifdef AXI_WRAP_BURST_EN
    wrap_len  = (len_q == LW'(1)) || (len_q == LW'(3)) ||
                (len_q == LW'(7)) || (len_q == LW'(15));
    wrap_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
`endif
    if (burst_q == 2'd0) begin
      addr_d = addr_q;
    end
`ifdef AXI_WRAP_BURST_EN
    else if ((burst_q == 2'd2) && wrap_len) begin
      addr_d = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
    end
`endif
  end

  // Sequencer state and beat registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_req_valid) begin
            state_q <= S_BURST;
            addr_q  <= i_req_addr;
            idx_q   <= '0;
            last_q  <= (i_req_len == '0);
            len_q   <= i_req_len;
            size_q  <= i_req_size;
            burst_q <= i_req_burst;
          end
        end
        S_BURST: begin
          if (i_beat_ready) begin
            if (last_q) begin
              state_q <= S_IDLE;
            end else begin
              addr_q <= addr_d;
              idx_q  <= idx_d;
              last_q <= (idx_d == len_q);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready  = (state_q == S_IDLE);
  assign o_beat_valid = (state_q == S_BURST);
  assign o_busy       = (state_q == S_BURST);
  assign o_beat_addr  = addr_q;
  assign o_beat_idx   = idx_q;
  assign o_beat_last  = last_q;

endmodule

// File: tb/tb_axi_burst_seq.sv
// Randomized self-checking bench for axi_burst_seq against an arithmetic per-beat address model.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef LEN_BITS
`define LEN_BITS 8
`endif
`ifndef SIZE_BITS
`define SIZE_BITS 3
`endif

module tb_axi_burst_seq;

  localparam int unsigned AW = `ADDR_WIDTH;
  localparam int unsigned LW = `LEN_BITS;
  localparam int unsigned SW = `SIZE_BITS;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [SW-1:0] req_size;
  logic [1:0]    req_burst;
  logic          beat_valid;
  logic          beat_ready;
  logic [AW-1:0] beat_addr;
  logic [LW-1:0] beat_idx;
  logic          beat_last;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_burst_seq dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_addr   (req_addr),
    .i_req_len    (req_len),
    .i_req_size   (req_size),
    .i_req_burst  (req_burst),
    .o_beat_valid (beat_valid),
    .i_beat_ready (beat_ready),
    .o_beat_addr  (beat_addr),
    .o_beat_idx   (beat_idx),
    .o_beat_last  (beat_last),
    .o_busy       (busy)
  );

  // Address of beat i computed directly from the burst rules (no iteration).
  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a, input logic [LW-1:0] l,
                                             input logic [SW-1:0] s, input logic [1:0] b,
                                             input int i);
    longint unsigned bytes, cont, lin;
    bytes = longint'(1) << s;
    lin   = longint'(a) + longint'(i) * bytes;
    if (b == 2'd0) return a;
`ifdef AXI_WRAP_BURST_EN
    if (b == 2'd2 && (l == 1 || l == 3 || l == 7 || l == 15)) begin
      cont = (longint'(l) + 1) * bytes;
      return AW'((longint'(a) / cont) * cont + (lin % cont));
    end
`else
    cont = 0;
`endif
    return AW'(lin);
  endfunction

  // Drive one request and walk every beat, stalling stall0 cycles on beat 0 and up to max_stall elsewhere.
  task automatic do_burst(input string name, input logic [AW-1:0] a, input logic [LW-1:0] l,
                          input logic [SW-1:0] s, input logic [1:0] b,
                          input int stall0, input int max_stall);
    logic [AW-1:0] ea;
    int            ns;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || beat_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle-before: ready=%b valid=%b required ready=1 valid=0", name, req_ready, beat_valid);
    end
    req_valid = 1'b1; req_addr = a; req_len = l; req_size = s; req_burst = b;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      ea = exp_addr(a, l, s, b, i);
      ns = (i == 0) ? stall0 : ((max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0);
      for (int k = 0; k <= ns; k++) begin
        n_tests++;
        if (beat_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0 || beat_addr !== ea ||
            beat_idx !== LW'(i) || beat_last !== (i == int'(l))) begin
          n_fail++;
          $display("FAIL %s beat%0d wait%0d: valid=%b busy=%b rdy=%b addr=%h idx=%0d last=%b required 1 1 0 addr=%h idx=%0d last=%b",
                   name, i, k, beat_valid, busy, req_ready, beat_addr, beat_idx, beat_last,
                   ea, i, (i == int'(l)));
        end
        beat_ready = (k == ns);
        @(negedge clk);
      end
    end
    beat_ready = 1'b0;
    n_tests++;
    if (beat_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s end: valid=%b ready=%b busy=%b required valid=0 ready=1 busy=0", name, beat_valid, req_ready, busy);
    end
  endtask

  task automatic check_idle(input string name);
    n_tests++;
    if (beat_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || beat_addr !== '0 ||
        beat_idx !== '0 || beat_last !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: valid=%b busy=%b ready=%b addr=%h idx=%0d last=%b required 0 0 1 0 0 0",
               name, beat_valid, busy, req_ready, beat_addr, beat_idx, beat_last);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; req_size = '0; req_burst = '0;
    beat_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
  endtask

  task automatic test_incr();
    do_burst("incr_0x1000", AW'(32'h1000), LW'(3), SW'(2), 2'd1, 0, 0);
    do_burst("incr_unaligned", AW'(32'h1003), LW'(4), SW'(1), 2'd1, 0, 1);
    do_burst("reserved_as_incr", AW'(32'h4000), LW'(2), SW'(3), 2'd3, 0, 1);
  endtask

  task automatic test_fixed();
    do_burst("fixed_0x2000", AW'(32'h2000), LW'(2), SW'(3), 2'd0, 0, 0);
  endtask

  task automatic test_wrap();
    do_burst("wrap_0x3018", AW'(32'h3018), LW'(3), SW'(3), 2'd2, 0, 0);
    do_burst("wrap_len7", AW'(32'h5034), LW'(7), SW'(2), 2'd2, 0, 1);
    do_burst("wrap_len2_incr", AW'(32'h3018), LW'(2), SW'(3), 2'd2, 0, 0);
  endtask

  task automatic test_overflow_stall();
    do_burst("incr_overflow_stall", AW'(32'hFFFF_FFFC), LW'(1), SW'(2), 2'd1, 3, 0);
  endtask

  task automatic test_len_extremes();
    do_burst("len0", AW'(32'h0ABC), LW'(0), SW'(0), 2'd1, 2, 0);
    do_burst("len255", AW'(32'h8000), LW'(255), SW'(0), 2'd1, 0, 0);
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk);
    req_valid = 1'b1; req_addr = AW'(32'h6000); req_len = LW'(7); req_size = SW'(2); req_burst = 2'd1;
    @(negedge clk);
    req_valid = 1'b0; beat_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (beat_valid !== 1'b1 || beat_idx !== LW'(2) || beat_addr !== AW'(32'h6008)) begin
      n_fail++;
      $display("FAIL rst_mid pre: valid=%b idx=%0d addr=%h required 1 2 6008", beat_valid, beat_idx, beat_addr);
    end
    rst = 1'b1; beat_ready = 1'b0;
    @(negedge clk);
    check_idle("rst_mid after");
    rst = 1'b0;
    do_burst("rst_mid new", AW'(32'h7010), LW'(2), SW'(2), 2'd1, 0, 1);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    logic [SW-1:0] s;
    logic [1:0]    b;
    for (int n = 0; n < 40; n++) begin
      a = AW'($urandom);
      b = 2'($urandom_range(3, 0));
      s = SW'($urandom_range(7, 0));
      case ($urandom_range(3, 0))
        0: l = LW'(1);
        1: l = LW'(3);
        2: l = LW'(7);
        default: l = LW'($urandom_range(20, 0));
      endcase
      do_burst("random", a, l, s, b, int'($urandom_range(2, 0)), 2);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_fixed();
    test_wrap();
    test_overflow_stall();
    test_len_extremes();
    test_reset_mid_burst();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
